// File: rtl/pll_nco.sv
// pll_nco: local-oscillator half of the all-digital PLL.
// Runs the decimated frequency-offset estimate through a PI loop filter that
// steers a phase-accumulator NCO, then converts the phase to a signed sinusoid
// with a quarter-wave table.
//
// Ports:
//   clk, rst_n      sample clock, asynchronous active-low reset
//   en              advance the phase accumulator
//   hold            freeze the loop filter (df_valid ignored while high)
//   df_valid, df    one-cycle strobe and signed frequency-offset estimate
//   B, B_valid      local sinusoid and its valid flag (3-stage pipeline)
//   fcw             current frequency control word (modulo 2^ACC_W)
//   phase           accumulator value
//   sat             sticky clamp indicator, cleared only by reset
module pll_nco #(
    parameter int unsigned      ACC_W      = 32,
    parameter logic [ACC_W-1:0] FCW_CENTER = ACC_W'(32'h0666_6666),
    parameter int unsigned      KP_SHIFT   = 8,
    parameter int unsigned      KI_SHIFT   = 4,
    parameter logic [ACC_W-1:0] FCW_LIM    = ACC_W'(32'h0100_0000),
    parameter int unsigned      LUT_AW     = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hold,
    input  logic                    df_valid,
    input  logic signed [15:0]      df,
    output logic signed [15:0]      B,
    output logic                    B_valid,
    output logic [ACC_W-1:0]        fcw,
    output logic [ACC_W-1:0]        phase,
    output logic                    sat
);

    localparam int unsigned DF_W  = 16;
    localparam int unsigned B_W   = 16;
    localparam int unsigned SUM_W = ACC_W + 2;
    localparam int unsigned LUT_N = 1 << LUT_AW;
    localparam real         HALF_PI = 1.5707963267948966;

    localparam logic signed [SUM_W-1:0] SUM_LIM_POS = SUM_W'(FCW_LIM);
    localparam logic signed [SUM_W-1:0] SUM_LIM_NEG = -SUM_LIM_POS;
    localparam logic [ACC_W-1:0]        LIM_NEG     = -FCW_LIM;

    // Sign-extend an ACC_W word to the guard-bit sum width.
    function automatic logic signed [SUM_W-1:0] sx(input logic [ACC_W-1:0] v);
        return {{2{v[ACC_W-1]}}, v};
    endfunction

    logic signed [ACC_W-1:0] p_reg;
    logic signed [ACC_W-1:0] integ;
    logic signed [ACC_W-1:0] df_ext;
    logic signed [SUM_W-1:0] integ_sum;
    logic signed [ACC_W-1:0] integ_next;
    logic                    integ_clip_c;
    logic signed [SUM_W-1:0] adj_sum;
    logic signed [ACC_W-1:0] adj_clamp;
    logic                    adj_clip_c;
    logic                    accept_c;

    // Stage-1 integrator update with clamp (evaluated every cycle, used on accept).
    always_comb begin
        accept_c     = df_valid & ~hold;
        df_ext       = {{(ACC_W-DF_W){df[DF_W-1]}}, df};
        integ_sum    = sx(integ) + sx(df_ext <<< KI_SHIFT);
        integ_next   = integ_sum[ACC_W-1:0];
        integ_clip_c = 1'b0;
        if (integ_sum > SUM_LIM_POS) begin
            integ_next   = FCW_LIM;
            integ_clip_c = 1'b1;
        end else if (integ_sum < SUM_LIM_NEG) begin
            integ_next   = LIM_NEG;
            integ_clip_c = 1'b1;
        end
    end

    // Stage-2 total adjustment with clamp.
    always_comb begin
        adj_sum    = sx(p_reg) + sx(integ);
        adj_clamp  = adj_sum[ACC_W-1:0];
        adj_clip_c = 1'b0;
        if (adj_sum > SUM_LIM_POS) begin
            adj_clamp  = FCW_LIM;
            adj_clip_c = 1'b1;
        end else if (adj_sum < SUM_LIM_NEG) begin
            adj_clamp  = LIM_NEG;
            adj_clip_c = 1'b1;
        end
    end

    // Loop filter registers and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_reg <= '0;
            integ <= '0;
            fcw   <= FCW_CENTER;
            sat   <= 1'b0;
        end else begin
            if (accept_c) begin
                p_reg <= df_ext <<< KP_SHIFT;
                integ <= integ_next;
            end
            fcw <= FCW_CENTER + adj_clamp;
            if ((accept_c && integ_clip_c) || adj_clip_c) begin
                sat <= 1'b1;
            end
        end
    end

    // Phase accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (en) begin
            phase <= phase + fcw;
        end
    end

    // Quarter-wave table, sampled at half-step offsets so mirroring is exact.
    logic [B_W-1:0] rom [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        localparam real THETA = HALF_PI * ($itor(k) + 0.5) / $itor(LUT_N);
        assign rom[k] = B_W'($rtoi(32767.0 * $sin(THETA) + 0.5));
    end

    logic [LUT_AW-1:0] a1;
    logic              neg1;
    logic              v1;
    logic [B_W-1:0]    rom_q;
    logic              neg2;
    logic              v2;

    // S1 address fold, S2 table read, S3 sign; B only moves on valid samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1      <= '0;
            neg1    <= 1'b0;
            v1      <= 1'b0;
            rom_q   <= '0;
            neg2    <= 1'b0;
            v2      <= 1'b0;
            B       <= '0;
            B_valid <= 1'b0;
        end else begin
            a1      <= phase[ACC_W-2] ? ~phase[ACC_W-3 -: LUT_AW] : phase[ACC_W-3 -: LUT_AW];
            neg1    <= phase[ACC_W-1];
            v1      <= en;
            rom_q   <= rom[a1];
            neg2    <= neg1;
            v2      <= v1;
            B_valid <= v2;
            if (v2) begin
                B <= neg2 ? -rom_q : rom_q;
            end
        end
    end

endmodule

// File: tb/tb_pll_nco.sv
// Testbench for pll_nco: randomized and directed stimulus checked against a
// cycle-level arithmetic reference model of the loop filter, NCO and sine output.
module tb_pll_nco;

    localparam logic [31:0] CENTER  = 32'h0666_6666;
    localparam logic [31:0] CENTER2 = 32'h4000_0000;
    localparam longint      LIM     = 64'sd16777216;
    localparam real         PI      = 3.14159265358979323846;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, en, hold, df_valid;
    logic signed [15:0] df;
    logic signed [15:0] B;
    logic               B_valid;
    logic [31:0]        fcw, phase;
    logic               sat;

    logic               rst2_n, en2;
    logic signed [15:0] B2;
    logic               B2_valid;
    logic [31:0]        fcw2, phase2;
    logic               sat2;

    pll_nco dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hold(hold), .df_valid(df_valid), .df(df),
        .B(B), .B_valid(B_valid), .fcw(fcw), .phase(phase), .sat(sat)
    );

    pll_nco #(.FCW_CENTER(CENTER2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .en(en2), .hold(1'b0), .df_valid(1'b0), .df(16'sd0),
        .B(B2), .B_valid(B2_valid), .fcw(fcw2), .phase(phase2), .sat(sat2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    longint             m_p, m_i;
    logic [31:0]        m_fcw, m_phase;
    logic               m_sat, m_bv;
    logic signed [15:0] m_b;
    logic               h_en [2];
    logic [31:0]        h_ph [2];

    function automatic logic signed [15:0] ref_sine(input logic [31:0] ph);
        int idx;
        int mag;
        idx = int'(ph[29:20]);
        if (ph[30]) idx = 1023 - idx;
        mag = $rtoi(32767.0 * $sin(PI / 2.0 * ($itor(idx) + 0.5) / 1024.0) + 0.5);
        return ph[31] ? 16'(-mag) : 16'(mag);
    endfunction

    task automatic model_reset();
        m_p = 0; m_i = 0; m_fcw = CENTER; m_phase = '0; m_sat = 1'b0;
        m_bv = 1'b0; m_b = '0;
        h_en[0] = 1'b0; h_en[1] = 1'b0; h_ph[0] = '0; h_ph[1] = '0;
    endtask

    task automatic model_edge(input logic e, input logic h, input logic v, input logic signed [15:0] d);
        longint adj, s;
        logic [31:0] nfcw;
        adj = m_p + m_i;
        if (adj > LIM) begin adj = LIM; m_sat = 1'b1; end
        else if (adj < -LIM) begin adj = -LIM; m_sat = 1'b1; end
        nfcw = CENTER + 32'(adj);
        if (v && !h) begin
            s = m_i + longint'(d) * 64'sd16;
            if (s > LIM) begin s = LIM; m_sat = 1'b1; end
            else if (s < -LIM) begin s = -LIM; m_sat = 1'b1; end
            m_p = longint'(d) * 64'sd256;
            m_i = s;
        end
        // sample on the output = phase held two edges back, gated by en at that edge
        m_bv = h_en[1];
        if (h_en[1]) m_b = ref_sine(h_ph[1]);
        h_en[1] = h_en[0]; h_ph[1] = h_ph[0];
        h_en[0] = e;       h_ph[0] = m_phase;
        if (e) m_phase = m_phase + m_fcw;
        m_fcw = nfcw;
    endtask

    task automatic tick(input logic e, input logic h, input logic v, input logic signed [15:0] d);
        en = e; hold = h; df_valid = v; df = d;
        @(posedge clk);
        model_edge(e, h, v, d);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_ph;
        rst_n = 1'b0; en = 1'b0; hold = 1'b0; df_valid = 1'b0; df = '0;
        #12;
        checks++; if (B !== 16'sd0) begin errors++; $display("FAIL reset_B got %0d exp 0", B); end
        checks++; if (B_valid !== 1'b0) begin errors++; $display("FAIL reset_B_valid got %b exp 0", B_valid); end
        checks++; if (fcw !== CENTER) begin errors++; $display("FAIL reset_fcw got %h exp %h", fcw, CENTER); end
        checks++; if (phase !== 32'd0) begin errors++; $display("FAIL reset_phase got %h exp 0", phase); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %b exp 0", sat); end
        @(negedge clk);
        en = 1'b1; rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 12; k++) begin
            tick(1'b1, 1'b0, 1'b0, 16'sd0);
            exp_ph = CENTER * 32'(k);
            checks++; if (phase !== exp_ph) begin errors++; $display("FAIL free_phase k=%0d got %h exp %h", k, phase, exp_ph); end
            checks++; if (fcw !== CENTER) begin errors++; $display("FAIL free_fcw k=%0d got %h exp %h", k, fcw, CENTER); end
            checks++; if (B_valid !== (k >= 3)) begin errors++; $display("FAIL free_B_valid k=%0d got %b exp %b", k, B_valid, (k >= 3)); end
            checks++; if (B !== m_b) begin errors++; $display("FAIL free_B k=%0d got %0d exp %0d", k, B, m_b); end
            checks++; if (sat !== 1'b0) begin errors++; $display("FAIL free_sat k=%0d got %b exp 0", k, sat); end
        end
    endtask

    task automatic test_quadrants();
        logic signed [15:0] pat [4];
        logic [31:0] exp_ph;
        pat[0] = 16'sd25; pat[1] = 16'sd32767; pat[2] = -16'sd25; pat[3] = -16'sd32767;
        en2 = 1'b1;
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick(1'b1, 1'b0, 1'b0, 16'sd0);
            exp_ph = 32'(k) << 30;
            checks++; if (phase2 !== exp_ph) begin errors++; $display("FAIL quad_phase k=%0d got %h exp %h", k, phase2, exp_ph); end
            checks++; if (fcw2 !== CENTER2 || sat2 !== 1'b0) begin errors++; $display("FAIL quad_fcw k=%0d got %h/%b exp %h/0", k, fcw2, sat2, CENTER2); end
            if (k >= 3) begin
                checks++; if (B2 !== pat[(k-3)%4] || B2_valid !== 1'b1) begin
                    errors++; $display("FAIL quad_B k=%0d got %0d/%b exp %0d/1", k, B2, B2_valid, pat[(k-3)%4]);
                end
            end
        end
    endtask

    task automatic test_df_step();
        tick(1'b1, 1'b0, 1'b1, 16'sd100);
        checks++; if (fcw !== CENTER) begin errors++; $display("FAIL step_fcw_early got %h exp %h", fcw, CENTER); end
        tick(1'b1, 1'b0, 1'b0, 16'sd0);
        for (int k = 0; k < 5; k++) begin
            checks++; if (fcw !== CENTER + 32'd27200) begin errors++; $display("FAIL step_fcw k=%0d got %h exp %h", k, fcw, CENTER + 32'd27200); end
            checks++; if (phase !== m_phase) begin errors++; $display("FAIL step_phase k=%0d got %h exp %h", k, phase, m_phase); end
            checks++; if (B !== m_b || B_valid !== m_bv) begin errors++; $display("FAIL step_B k=%0d got %0d/%b exp %0d/%b", k, B, B_valid, m_b, m_bv); end
            tick(1'b1, 1'b0, 1'b0, 16'sd0);
        end
        tick(1'b1, 1'b0, 1'b1, 16'sd0);
        tick(1'b1, 1'b0, 1'b0, 16'sd0);
        checks++; if (fcw !== CENTER + 32'd1600) begin errors++; $display("FAIL step_fcw_zero got %h exp %h", fcw, CENTER + 32'd1600); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL step_sat got %b exp 0", sat); end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, 1'b0, 1'b1, 16'sd32767);
            checks++; if (fcw !== m_fcw || sat !== m_sat) begin errors++; $display("FAIL satup_fcw k=%0d got %h/%b exp %h/%b", k, fcw, sat, m_fcw, m_sat); end
        end
        checks++; if (fcw !== CENTER + 32'h0100_0000) begin errors++; $display("FAIL sat_fcw_top got %h exp %h", fcw, CENTER + 32'h0100_0000); end
        checks++; if (sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %b exp 1", sat); end
        tick(1'b1, 1'b0, 1'b1, 16'sh8000);
        tick(1'b1, 1'b0, 1'b0, 16'sd0);
        checks++; if (fcw !== CENTER + 32'd7864320) begin errors++; $display("FAIL sat_walk1 got %h exp %h", fcw, CENTER + 32'd7864320); end
        for (int k = 0; k < 80; k++) begin
            tick(1'b1, 1'b0, 1'b1, 16'sh8000);
            checks++; if (fcw !== m_fcw || sat !== 1'b1) begin errors++; $display("FAIL satdn_fcw k=%0d got %h/%b exp %h/1", k, fcw, sat, m_fcw); end
        end
        tick(1'b1, 1'b0, 1'b0, 16'sd0);
        checks++; if (fcw !== CENTER - 32'h0100_0000) begin errors++; $display("FAIL sat_fcw_bot got %h exp %h", fcw, CENTER - 32'h0100_0000); end
    endtask

    task automatic test_hold();
        logic [31:0] exp_fcw;
        exp_fcw = m_fcw;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) tick(1'b1, 1'b1, 1'b1, 16'sd500);
            else       tick(1'b1, 1'b0, 1'b0, 16'sd0);
            checks++; if (fcw !== exp_fcw) begin errors++; $display("FAIL hold_fcw k=%0d got %h exp %h", k, fcw, exp_fcw); end
        end
        tick(1'b1, 1'b0, 1'b1, 16'sd500);
        tick(1'b1, 1'b0, 1'b0, 16'sd0);
        checks++; if (fcw !== m_fcw) begin errors++; $display("FAIL hold_release got %h exp %h", fcw, m_fcw); end
    endtask

    task automatic test_random();
        logic e, h, v;
        logic signed [15:0] d;
        for (int k = 0; k < 400; k++) begin
            e = ($urandom_range(0, 3) != 0);
            h = ($urandom_range(0, 4) == 0);
            v = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) d = 16'($urandom);
            else                           d = 16'(int'($urandom_range(0, 2000)) - 1000);
            tick(e, h, v, d);
            checks++; if (fcw !== m_fcw) begin errors++; $display("FAIL rnd_fcw k=%0d got %h exp %h", k, fcw, m_fcw); end
            checks++; if (phase !== m_phase) begin errors++; $display("FAIL rnd_phase k=%0d got %h exp %h", k, phase, m_phase); end
            checks++; if (B !== m_b) begin errors++; $display("FAIL rnd_B k=%0d got %0d exp %0d", k, B, m_b); end
            checks++; if (B_valid !== m_bv) begin errors++; $display("FAIL rnd_B_valid k=%0d got %b exp %b", k, B_valid, m_bv); end
            checks++; if (sat !== m_sat) begin errors++; $display("FAIL rnd_sat k=%0d got %b exp %b", k, sat, m_sat); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp_ph;
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 1'b1, 16'sd300);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (B !== 16'sd0) begin errors++; $display("FAIL areset_B got %0d exp 0", B); end
        checks++; if (phase !== 32'd0) begin errors++; $display("FAIL areset_phase got %h exp 0", phase); end
        checks++; if (fcw !== CENTER) begin errors++; $display("FAIL areset_fcw got %h exp %h", fcw, CENTER); end
        checks++; if (sat !== 1'b0) begin errors++; $display("FAIL areset_sat got %b exp 0", sat); end
        checks++; if (B_valid !== 1'b0) begin errors++; $display("FAIL areset_B_valid got %b exp 0", B_valid); end
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (phase !== 32'd0) begin errors++; $display("FAIL areset_hold_phase got %h exp 0", phase); end
        @(negedge clk);
        en = 1'b1; df_valid = 1'b0; rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick(1'b1, 1'b0, 1'b0, 16'sd0);
            exp_ph = CENTER * 32'(k);
            checks++; if (phase !== exp_ph) begin errors++; $display("FAIL restart_phase k=%0d got %h exp %h", k, phase, exp_ph); end
            checks++; if (fcw !== CENTER) begin errors++; $display("FAIL restart_fcw k=%0d got %h exp %h", k, fcw, CENTER); end
            checks++; if (B !== m_b || B_valid !== m_bv) begin errors++; $display("FAIL restart_B k=%0d got %0d/%b exp %0d/%b", k, B, B_valid, m_b, m_bv); end
        end
    endtask

    initial begin
        rst2_n = 1'b0;
        en2    = 1'b0;
        test_reset();
        test_quadrants();
        test_df_step();
        test_saturate();
        test_hold();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_nco.md
Name: pll_nco

Overview:
- Local-oscillator half of the all-digital PLL. Takes the filtered frequency-offset estimate `df` from the phase-detector/FIR chain and runs it through a proportional-integral loop filter.
- Steers a phase-accumulator NCO, which produces the signed local sinusoid `B` fed back to the detector's multiplier.
- Everything runs in the fast sample clock domain. Decimated `df` updates arrive as one-cycle `df_valid` strobes.

Parameters:
- ACC_W, 32: phase accumulator / frequency control word (FCW) width.
- FCW_CENTER, 32'h0666_6666: free-running FCW (nominal frequency).
- KP_SHIFT, 8: proportional gain, applied as df <<< KP_SHIFT.
- KI_SHIFT, 4: integral gain, applied as df <<< KI_SHIFT per update.
- FCW_LIM, 32'h0100_0000: symmetric clamp ±FCW_LIM on the integrator and on the total adjustment.
- LUT_AW, 10: quarter-wave sine table address width (1024 entries, 16 bits each).

Ports:
- clk, input, 1: sample clock.
- rst_n, input, 1: asynchronous, active-low reset.
- en, input, 1: phase accumulator advance enable.
- hold, input, 1: freeze the loop filter; df_valid is ignored while high.
- df_valid, input, 1: one-cycle strobe marking a new df.
- df, input, 16 signed: frequency-offset estimate from the detector.
- B, output, 16 signed: local sinusoid.
- B_valid, output, 1: B carries a sample produced from an enabled phase.
- fcw, output, ACC_W: current control word (unsigned, modulo 2^ACC_W).
- phase, output, ACC_W: accumulator value.
- sat, output, 1: sticky flag, set when any clamp engaged; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - integ=0, p_reg=0, fcw=FCW_CENTER, phase=0, B=0, B_valid=0, sat=0.
  - Releasing reset mid-operation restarts from these values.
- Loop filter stage 1, on an edge with df_valid=1 and hold=0:
  - df is sign-extended to ACC_W.
  - p_reg <= df<<<KP_SHIFT.
  - integ <= clamp(integ + (df<<<KI_SHIFT), ±FCW_LIM).
  - The sum is computed at ACC_W+2 bits so it cannot overflow before clamping.
  - Otherwise p_reg and integ hold their values.
- Loop filter stage 2, every cycle:
  - fcw <= FCW_CENTER + clamp(p_reg + integ, ±FCW_LIM), wrapping modulo 2^ACC_W.
  - fcw therefore reflects a strobe 2 cycles after the df_valid edge.
  - The proportional term persists until the next accepted strobe.
- Clamps:
  - Saturate to exactly +FCW_LIM or -FCW_LIM.
  - sat <= 1 on the same edge a clamp engages.
- Accumulator:
  - When en=1, phase <= phase + fcw (mod 2^ACC_W) every cycle.
  - When en=0, phase holds. The loop filter keeps running regardless of en.
- Sine generation, 3-stage pipeline:
  - S1: q = phase[ACC_W-1:ACC_W-2]; a = phase[ACC_W-3 -: LUT_AW]; a is inverted when q is odd.
  - S2: ROM read, entry k = round(32767*sin(pi/2*(k+0.5)/2^LUT_AW)).
  - S3: B <= negated when q>=2, else the ROM value. Negation is exact because table values are ≤32767.
- Pipeline timing:
  - B corresponds to the phase value that was registered 3 edges earlier.
  - B_valid follows en delayed by 3 cycles.
  - When en=0, B holds its last value.
- Simultaneous events:
  - hold=1 together with df_valid=1: the strobe is dropped, not queued.
  - A strobe arriving while stage 2 is updating is processed normally; stages are independent registers, so no collision is possible.

Test Plan:
- Reset, en=1 from cycle 0, no df_valid:
  - phase = k*0x0666_6666 mod 2^32.
  - fcw=0x0666_6666 constant.
  - B_valid first high 3 cycles after en; sat=0.
- Set FCW_CENTER=0x4000_0000, en=1:
  - B repeats 25, 32767, -25, -32767 (phase 0, 2^30, 2^31, 3·2^30).
  - Confirms mirroring and negation.
- One df_valid with df=100, defaults:
  - integ=1600, p_reg=25600.
  - fcw=center+27200 two cycles after the strobe, held thereafter.
  - Next strobe df=0 → fcw=center+1600.
- df=32767 strobed repeatedly:
  - integ clamps at 0x0100_0000; fcw=center+0x0100_0000; sat=1 and stays 1.
  - Subsequent df=-32768 strobes walk integ down with no wrap.
- hold=1 with df_valid=1, df=500 → p_reg, integ and fcw unchanged.
- Assert rst_n=0 asynchronously mid-run, between clock edges:
  - B, phase, integ and sat clear immediately; fcw=FCW_CENTER.
  - After release, the phase sequence restarts from 0.
